// File: rtl/johnring_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | johnring_monitor: decodes and sequence-checks a 6-bit ring/Johnson state |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module johnring_monitor #(
  parameter int ILL_THRESH = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       mode,
  input  logic [5:0] q_in,
  output logic [3:0] phase,
  output logic       phase_valid,
  output logic       illegal,
  output logic       step_err,
  output logic [7:0] rev_cnt,
  output logic [7:0] err_cnt,
  output logic       recover_req
);

  localparam logic [3:0] THRESH = 4'(ILL_THRESH);

  logic [3:0] ill_cnt;
  logic       hist_valid;
  logic       prev_mode;

  logic       ring_legal;
  logic [3:0] ring_phase;
  logic [2:0] pop;
  logic       john_legal;
  logic [3:0] john_phase;
  logic       legal;
  logic [3:0] new_phase;
  logic [3:0] n_last;
  logic [3:0] succ;
  logic       checked;
  logic       step_bad;
  logic       wrap;
  logic [3:0] ill_next;

  always_comb begin
    ring_legal = 1'b0;
    ring_phase = 4'd0;
    pop        = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (q_in == (6'd1 << i)) begin
        ring_legal = 1'b1;
        ring_phase = 4'(i);
      end
      pop = pop + {2'b00, q_in[i]};
    end
  end

  // Johnson states are a contiguous run of ones anchored at bit 0 or bit 5.
  always_comb begin
    john_legal = ((q_in & (q_in + 6'd1)) == 6'd0) ||
                 ((~q_in & (~q_in + 6'd1)) == 6'd0);
    if (q_in == 6'd0)
      john_phase = 4'd0;
    else if (q_in[0])
      john_phase = {1'b0, pop};
    else
      john_phase = 4'd12 - {1'b0, pop};
  end

  always_comb begin
    legal     = mode ? john_legal : ring_legal;
    new_phase = mode ? john_phase : ring_phase;
    n_last    = mode ? 4'd11 : 4'd5;
    succ      = (phase == n_last) ? 4'd0 : phase + 4'd1;
    checked   = legal && hist_valid && (mode == prev_mode);
    step_bad  = checked && (new_phase != phase) && (new_phase != succ);
    wrap      = checked && (phase == n_last) && (new_phase == 4'd0);
    ill_next  = ill_cnt + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase       <= 4'd0;
      phase_valid <= 1'b0;
      illegal     <= 1'b0;
      step_err    <= 1'b0;
      rev_cnt     <= 8'd0;
      err_cnt     <= 8'd0;
      recover_req <= 1'b0;
      ill_cnt     <= 4'd0;
      hist_valid  <= 1'b0;
      prev_mode   <= 1'b0;
    end else if (!en) begin
      step_err    <= 1'b0;
      recover_req <= 1'b0;
    end else begin
      prev_mode   <= mode;
      phase_valid <= legal;
      illegal     <= !legal;
      hist_valid  <= legal;
      step_err    <= step_bad;
      if ((!legal || step_bad) && (err_cnt != 8'hFF))
        err_cnt <= err_cnt + 8'd1;
      if (legal) begin
        phase       <= new_phase;
        ill_cnt     <= 4'd0;
        recover_req <= 1'b0;
        if (wrap)
          rev_cnt <= rev_cnt + 8'd1;
      end else if (ill_next == THRESH) begin
        ill_cnt     <= 4'd0;
        recover_req <= 1'b1;
      end else begin
        ill_cnt     <= ill_next;
        recover_req <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_johnring_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_johnring_monitor: directed vectors plus randomized model comparison   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_johnring_monitor;

  localparam int ILL_THRESH = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       mode;
  logic [5:0] q_in;
  logic [3:0] phase;
  logic       phase_valid;
  logic       illegal;
  logic       step_err;
  logic [7:0] rev_cnt;
  logic [7:0] err_cnt;
  logic       recover_req;

  johnring_monitor #(.ILL_THRESH(ILL_THRESH)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .q_in(q_in),
    .phase(phase), .phase_valid(phase_valid), .illegal(illegal),
    .step_err(step_err), .rev_cnt(rev_cnt), .err_cnt(err_cnt),
    .recover_req(recover_req)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       en;
    logic       mode;
    logic [5:0] q;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  // reference model state
  int m_phase, m_valid, m_ill, m_step, m_rev, m_err, m_rec, m_cnt, m_hist, m_mode;

  function automatic logic [23:0] pack(int ph, int v, int il, int st, int rv, int er, int rc);
    return {4'(ph), 1'(v), 1'(il), 1'(st), 8'(rv), 8'(er), 1'(rc)};
  endfunction

  function automatic int jstate(int p);
    if (p <= 6) return (1 << p) - 1;
    return 63 & ~((1 << (p - 6)) - 1);
  endfunction

  function automatic int encode(int m, int p);
    return m ? jstate(p) : (1 << p);
  endfunction

  // returns the phase of a legal state, -1 for an illegal one
  function automatic int decode(int m, int q);
    int n = m ? 12 : 6;
    for (int p = 0; p < n; p++)
      if (encode(m, p) == q) return p;
    return -1;
  endfunction

  task automatic model_step(input int r, input int e, input int m, input int q);
    int ph, n;
    if (r != 0) begin
      m_phase = 0; m_valid = 0; m_ill = 0; m_step = 0; m_rev = 0;
      m_err = 0; m_rec = 0; m_cnt = 0; m_hist = 0; m_mode = 0;
    end else if (e == 0) begin
      m_step = 0; m_rec = 0;
    end else begin
      ph = decode(m, q);
      n  = m ? 12 : 6;
      m_step = 0; m_rec = 0;
      if (ph < 0) begin
        m_valid = 0; m_ill = 1; m_hist = 0;
        if (m_err < 255) m_err++;
        m_cnt++;
        if (m_cnt == ILL_THRESH) begin m_rec = 1; m_cnt = 0; end
      end else begin
        if (m_hist != 0 && m_mode == m) begin
          if (ph != m_phase && ph != (m_phase + 1) % n) begin
            m_step = 1;
            if (m_err < 255) m_err++;
          end else if (m_phase == n - 1 && ph == 0) begin
            m_rev = (m_rev + 1) % 256;
          end
        end
        m_phase = ph; m_valid = 1; m_ill = 0; m_cnt = 0; m_hist = 1;
      end
      m_mode = m;
    end
  endtask

  function automatic logic [23:0] model_out();
    return pack(m_phase, m_valid, m_ill, m_step, m_rev, m_err, m_rec);
  endfunction

  function automatic logic [23:0] dut_out();
    return {phase, phase_valid, illegal, step_err, rev_cnt, err_cnt, recover_req};
  endfunction

  task automatic drive(input logic r, input logic e, input logic m, input logic [5:0] q);
    @(negedge clk);
    reset = r; en = e; mode = m; q_in = q;
    model_step(int'(r), int'(e), int'(m), int'(q));
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (phase,valid,ill,step,rev,err,rec)", name, act, exp);
    end
  endtask

  task automatic add(input int r, input int e, input int m, input int q,
                     input int ph, input int v, input int il, input int st,
                     input int rv, input int er, input int rc);
    vec_t t;
    t.rst = 1'(r); t.en = 1'(e); t.mode = 1'(m); t.q = 6'(q);
    t.exp = pack(ph, v, il, st, rv, er, rc);
    vecs.push_back(t);
  endtask

  initial begin
    int p, n, sel, cm;
    logic r, e, m;
    logic [5:0] q;
    reset = 1'b1; en = 1'b0; mode = 1'b0; q_in = 6'd0;
    model_step(1, 0, 0, 0);

    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) add(0, 1, 0, 1 << i, i, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 1, 0, 0, 1, 0, 0);
    add(0, 1, 0, 'b000100, 2, 1, 0, 1, 1, 1, 0);
    add(0, 0, 0, 'b000101, 2, 1, 0, 0, 1, 1, 0);
    add(0, 1, 0, 'b001000, 3, 1, 0, 0, 1, 1, 0);
    add(1, 1, 0, 'b000101, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 7; k++)
      add(0, 1, 0, 'b000101, 0, 0, 1, 0, 0, k, (k == 3 || k == 6) ? 1 : 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) add(0, 1, 1, jstate(i), i, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 1, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) add(0, 1, 1, 'b000111, 3, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 'b001111, 4, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 'b001000, 3, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 'b000011, 2, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 'b000001, 1, 1, 0, 1, 0, 1, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].q);
      check($sformatf("vec%0d", i), dut_out(), vecs[i].exp);
    end

    // error counter saturation, then reset in the middle of an illegal run
    drive(1'b1, 1'b0, 1'b0, 6'd0);
    for (int k = 0; k < 300; k++) drive(1'b0, 1'b1, 1'b0, 6'b000101);
    check("err_sat", {16'd0, err_cnt}, 24'd255);
    drive(1'b0, 1'b1, 1'b0, 6'b000101);
    check("err_hold", dut_out(), model_out());
    drive(1'b1, 1'b1, 1'b0, 6'b000101);
    check("mid_reset", dut_out(), 24'd0);

    for (int k = 0; k < 800; k++) begin
      r  = ($urandom_range(0, 99) < 2);
      e  = ($urandom_range(0, 99) < 85);
      m  = ($urandom_range(0, 99) < 8) ? ~mode : mode;
      cm = int'(m);
      n  = m ? 12 : 6;
      sel = $urandom_range(0, 3);
      if (sel < 2) begin
        p = (m_phase + $urandom_range(0, 1)) % n;
        q = 6'(encode(cm, p));
      end else if (sel == 2) begin
        p = $urandom_range(0, n - 1);
        q = 6'(encode(cm, p));
      end else begin
        q = 6'($urandom_range(0, 63));
      end
      drive(r, e, m, q);
      check($sformatf("rand%0d", k), dut_out(), model_out());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/johnring_monitor.md
JOHNRING_MONITOR -- requirements
Module: johnring_monitor

Interface
REQ-001 Parameter ILL_THRESH, default 3, SHALL set the number of consecutive illegal samples (1..15) that triggers recovery.
REQ-002 clk  input  1  SHALL be the clock; all state changes occur on the rising edge.
REQ-003 reset  input  1  SHALL be the reset: synchronous, active-high, clock clk.
REQ-004 en  input  1  SHALL enable sampling; when low, all registers hold and pulse outputs are 0.
REQ-005 mode  input  1  SHALL select the decode: 0 = 6-state ring, 1 = 12-state twisted-ring (Johnson).
REQ-006 q_in  input  6  SHALL be the upstream 6-bit counter state.
REQ-007 phase  output  4  SHALL give the decoded phase index of the last sample.
REQ-008 phase_valid  output  1  SHALL be high when the last sample was a legal state.
REQ-009 illegal  output  1  SHALL be high when the last sample was not a legal state.
REQ-010 step_err  output  1  SHALL be a one-cycle pulse flagging an out-of-sequence legal transition.
REQ-011 rev_cnt  output  8  SHALL count completed revolutions, wrapping modulo 256.
REQ-012 err_cnt  output  8  SHALL count illegal samples plus step errors, saturating at 255.
REQ-013 recover_req  output  1  SHALL be a one-cycle pulse requesting upstream counter reset.

Function
REQ-014 On each rising edge with en=1, the block SHALL sample q_in and mode and SHALL update all outputs from that sample, giving 1-cycle latency.
REQ-015 In ring mode, legal states SHALL be exactly one bit set, and phase SHALL be the index of that bit (0..5).
REQ-016 In Johnson mode, legal states SHALL be the 12 states 000000, 000001, 000011 ... 111111, 111110 ... 100000.
REQ-017 In Johnson mode, phase SHALL be 0 for 000000, popcount(q_in) when q_in[0]=1, and 12-popcount(q_in) otherwise.
REQ-018 For an illegal sample, the block SHALL set phase_valid=0 and illegal=1, and SHALL hold phase at its previous value.
REQ-019 Step check, legal sample following a legal sample in the same mode: the next phase SHALL be allowed to equal prev or (prev+1) mod N (N=6 ring, 12 Johnson); any other value SHALL pulse step_err.
REQ-020 No step check SHALL be made on the first legal sample after reset, after an illegal sample, or after a mode change.
REQ-021 rev_cnt SHALL increment when a checked legal step goes from phase N-1 to phase 0.
REQ-022 An internal consecutive-illegal counter SHALL increment on each illegal sample and clear on each legal sample.
REQ-023 When the consecutive-illegal counter reaches ILL_THRESH, the block SHALL pulse recover_req for one cycle and clear that counter.
REQ-024 Each further ILL_THRESH consecutive illegal samples SHALL re-pulse recover_req.
REQ-025 err_cnt SHALL increment by 1 per illegal sample or step_err and SHALL stay at 255 once reached; illegal and step_err SHALL NOT both occur for the same sample.
REQ-026 A mode change with a legal sample in the new mode SHALL decode per the new mode and SHALL NOT produce step_err.
REQ-027 When en=0, step_err and recover_req SHALL be 0, and the prior sample history SHALL be retained for the next step check.

Reset
REQ-028 While reset=1, the block SHALL drive phase=0, phase_valid=0, illegal=0, step_err=0, rev_cnt=0, err_cnt=0 and recover_req=0.
REQ-029 While reset=1, the block SHALL clear the consecutive-illegal counter, the step history and the stored mode.
REQ-030 reset SHALL take priority over en, including a reset asserted mid-sequence.
REQ-031 The first edge after reset deasserts SHALL sample normally, with no step check.

Verification
REQ-032 Ring mode, q_in = 000001,000010,...,100000,000001 over 7 cycles -> phase 0..5,0; rev_cnt=1; step_err never asserted.
REQ-033 Johnson mode, full 12-state sequence then 000000 -> phase 0..11,0; rev_cnt=1; err_cnt=0.
REQ-034 Ring mode, 000001 then 000100 -> step_err pulses once; err_cnt=1; phase=2.
REQ-035 ILL_THRESH=3, q_in=000101 for 7 cycles -> illegal=1 throughout; recover_req pulses on the 3rd and 6th samples; err_cnt=7.
REQ-036 Johnson sequence held at 000111 for 4 cycles then 001111 -> no step_err; mode flipped to ring with q_in=001000 -> phase=3, no step_err.
REQ-037 err_cnt forced to 255 via 300 illegal samples, then reset asserted mid-run -> err_cnt stays at 255 until reset; every output reads 0 after the reset edge.
